i2c_target: RTL

Byte-addressed I2C target (responder) holding a small register memory, built as the bus-side counterpart of the BE8 core's I2C controller. Sits on the shared SCL/SDA pair, recognises its 7-bit address, accepts a pointer byte plus data writes, and returns memory contents on reads. Used on-chip as a scratch/config peripheral and in the bench as the far end of the controller's transfers.

---
 rtl/i2c_target_if.sv | 25 ++
 rtl/i2c_target.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_if.sv
// Bus-side bundle for i2c_target: SCL/SDA line levels, open-drain SDA drive,
// the write-commit strobe group and the busy flag.
interface i2c_target_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          scl_i;
  logic          sda_i;
  logic          sda_o;
  logic          wr_stb;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;

  modport slave (
    input  scl_i, sda_i,
    output sda_o, wr_stb, wr_addr, wr_data, busy
  );

  modport master (
    output scl_i, sda_i,
    input  sda_o, wr_stb, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/i2c_target.sv
// Byte-addressed I2C target with a small register memory (pointer byte, then data).
// Optional macro I2C_TARGET_WRAP_EN: pointer wraps instead of saturating with NACK/0xFF.
module i2c_target #(
  parameter logic [6:0]  ADDR  = 7'h50,
  parameter int unsigned DEPTH = 16
) (
  input logic         clk,
  input logic         rst,
  i2c_target_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StWdata, StDataAck, StRdata, StRdAck, StIgnore
  } state_e;

  state_e        state_q;
  logic [2:0]    scl_sr, sda_sr;
  logic [3:0]    cnt_q;
  logic [7:0]    sr_q, tx_q;
  logic [AW-1:0] ptr_q;
  logic          rw_q, nack_q;
  logic [7:0]    mem [DEPTH];
  logic          sda_q, wr_stb_q, busy_q;
  logic [AW-1:0] wr_addr_q;
  logic [7:0]    wr_data_q;
`ifndef I2C_TARGET_WRAP_EN
  logic          end_q;
`endif

  // [0],[1] synchronise; [2] is the history bit for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sr <= 3'b111;
      sda_sr <= 3'b111;
    end else begin
      scl_sr <= {scl_sr[1:0], bus.scl_i};
      sda_sr <= {sda_sr[1:0], bus.sda_i};
    end
  end

  logic scl_s, scl_h, sda_s, sda_h;
  logic scl_rise, scl_fall, start_det, stop_det, ptr_last;
  logic [7:0] rx_byte, rd_byte;

  assign scl_s     = scl_sr[1];
  assign scl_h     = scl_sr[2];
  assign sda_s     = sda_sr[1];
  assign sda_h     = sda_sr[2];
  assign scl_rise  = scl_s & ~scl_h;
  assign scl_fall  = ~scl_s & scl_h;
  assign start_det = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;
  assign rx_byte   = {sr_q[6:0], sda_s};
  assign ptr_last  = (ptr_q == AW'(DEPTH - 1));
`ifdef I2C_TARGET_WRAP_EN
  assign rd_byte   = mem[ptr_q];
`else
  assign rd_byte   = end_q ? 8'hFF : mem[ptr_q];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      sr_q      <= 8'h00;
      tx_q      <= 8'hFF;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      nack_q    <= 1'b0;
      sda_q     <= 1'b1;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
      busy_q    <= 1'b0;
`ifndef I2C_TARGET_WRAP_EN
      end_q     <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      wr_stb_q <= 1'b0;
      if (start_det) begin
        state_q <= StAddr;
        cnt_q   <= 4'd0;
        busy_q  <= 1'b1;
        sda_q   <= 1'b1;
      end else if (stop_det) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
        sda_q   <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle, StIgnore: ;
          StAddr: begin
            if (scl_rise && cnt_q < 4'd8) begin
              sr_q  <= rx_byte;
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall && cnt_q == 4'd8) begin
              if (sr_q[7:1] == ADDR) begin
                sda_q   <= 1'b0;
                rw_q    <= sr_q[0];
                state_q <= StAddrAck;
              end else begin
                state_q <= StIgnore;
              end
            end
          end
          StAddrAck: begin
            if (scl_fall) begin
              cnt_q <= 4'd0;
              if (rw_q) begin
                sda_q   <= rd_byte[7];
                tx_q    <= {rd_byte[6:0], 1'b1};
                state_q <= StRdata;
              end else begin
                sda_q   <= 1'b1;
                state_q <= StPtr;
              end
            end
          end
          StPtr, StWdata: begin
            if (scl_rise && cnt_q < 4'd8) begin
              sr_q  <= rx_byte;
              cnt_q <= cnt_q + 4'd1;
              // Commit as soon as the 8th bit is in; the ACK slot only reports it
              if (cnt_q == 4'd7 && state_q == StWdata) begin
`ifdef I2C_TARGET_WRAP_EN
                nack_q       <= 1'b0;
                mem[ptr_q]   <= rx_byte;
                wr_stb_q     <= 1'b1;
                wr_addr_q    <= ptr_q;
                wr_data_q    <= rx_byte;
                ptr_q        <= ptr_q + 1'b1;
`else
                nack_q <= end_q;
                if (!end_q) begin
                  mem[ptr_q] <= rx_byte;
                  wr_stb_q   <= 1'b1;
                  wr_addr_q  <= ptr_q;
                  wr_data_q  <= rx_byte;
                  if (ptr_last) end_q <= 1'b1;
                  else          ptr_q <= ptr_q + 1'b1;
                end
`endif
              end
            end else if (scl_fall && cnt_q == 4'd8) begin
              if (state_q == StPtr) begin
                ptr_q <= sr_q[AW-1:0];
                sda_q <= 1'b0;
`ifndef I2C_TARGET_WRAP_EN
                end_q <= 1'b0;
`endif
              end else begin
                sda_q <= nack_q;
              end
              state_q <= StDataAck;
            end
          end
          StDataAck: begin
            if (scl_fall) begin
              sda_q   <= 1'b1;
              cnt_q   <= 4'd0;
              state_q <= StWdata;
            end
          end
          StRdata: begin
            if (scl_fall) begin
              cnt_q <= cnt_q + 4'd1;
              if (cnt_q == 4'd7) begin
                sda_q   <= 1'b1;
                state_q <= StRdAck;
`ifdef I2C_TARGET_WRAP_EN
                ptr_q <= ptr_q + 1'b1;
`else
                if (!end_q) begin
                  if (ptr_last) end_q <= 1'b1;
                  else          ptr_q <= ptr_q + 1'b1;
                end
`endif
              end else begin
                sda_q <= tx_q[7];
                tx_q  <= {tx_q[6:0], 1'b1};
              end
            end
          end
          StRdAck: begin
            if (scl_rise) begin
              nack_q <= sda_s;
            end else if (scl_fall) begin
              if (!nack_q) begin
                cnt_q   <= 4'd0;
                sda_q   <= rd_byte[7];
                tx_q    <= {rd_byte[6:0], 1'b1};
                state_q <= StRdata;
              end else begin
                state_q <= StIgnore;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.sda_o   = sda_q;
  assign bus.wr_stb  = wr_stb_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = busy_q;
endmodule
